// File: rtl/sector_avmm_noc_bridge.sv
// sector_avmm_noc_bridge: AVMM slave to 64-bit NoC flit bridge with in-order, bounded reads.
// Optional read timeout is compiled in with `define SECTOR_BRIDGE_RD_TIMEOUT_EN.
module sector_avmm_noc_bridge #(
  parameter logic [3:0] SECTOR_ID       = 4'd6,
  parameter int         MAX_OUTSTANDING = 4,
  parameter int         TAG_W           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] avmm_slave_address,
  input  logic [31:0] avmm_slave_writedata,
  input  logic        avmm_slave_write,
  input  logic        avmm_slave_read,
  output logic        avmm_slave_waitrequest,
  output logic [31:0] avmm_slave_readdata,
  output logic        avmm_slave_readdatavalid,
  output logic [63:0] noc_tx_data,
  output logic        noc_tx_valid,
  input  logic        noc_tx_ready,
  input  logic [63:0] noc_rx_data,
  input  logic        noc_rx_valid,
  output logic        noc_rx_ready,
  output logic        err_sticky
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic             alive_q;
  logic [63:0]      flit_q, flit_d;
  logic [TAG_W-1:0] itag_q, itag_d;
  logic [TAG_W-1:0] etag_q, etag_d;
  logic [OW-1:0]    outs_q, outs_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rdv_q, rdv_d;
  logic             err_q, err_d;

  logic rd_only, full, wait_c, accept;
  logic rx_hit, rx_bad, tmo;
  logic unused_rx;

  assign unused_rx = ^{noc_rx_data[61:58], noc_rx_data[51:32]};

  always_comb begin
    rd_only = avmm_slave_read & ~avmm_slave_write;
    full    = (outs_q == MAX_O);
    wait_c  = !alive_q || (state_q == SEND) || (rd_only && full);
    accept  = (avmm_slave_write | avmm_slave_read) & ~wait_c;
    rx_hit  = noc_rx_valid && alive_q
           && (noc_rx_data[63:62] == 2'b11)
           && (noc_rx_data[57:52] == 6'(etag_q))
           && (outs_q != '0);
    rx_bad  = noc_rx_valid && alive_q && !rx_hit;
  end

`ifdef SECTOR_BRIDGE_RD_TIMEOUT_EN
  logic [15:0] tmo_q;

  assign tmo = (tmo_q == 16'hFFFF) && !rx_hit && (outs_q != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (rx_hit || tmo || outs_q == '0) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 16'd1;
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    flit_d  = flit_q;
    itag_d  = itag_q;
    etag_d  = etag_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    err_d   = err_q | rx_bad;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          if (avmm_slave_write) begin
            flit_d = {2'b01, SECTOR_ID, 6'd0,
                      avmm_slave_address, avmm_slave_writedata};
            // a simultaneous read is dropped and flagged
            err_d  = err_d | avmm_slave_read;
          end else begin
            flit_d = {2'b10, SECTOR_ID, 6'(itag_q),
                      avmm_slave_address, 32'd0};
            itag_d = itag_q + 1'b1;
          end
        end
      end
      SEND: begin
        if (noc_tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rx_hit) begin
      rdata_d = noc_rx_data[31:0];
      rdv_d   = 1'b1;
      etag_d  = etag_q + 1'b1;
    end else if (tmo) begin
      rdata_d = 32'hDEADBEEF;
      rdv_d   = 1'b1;
      etag_d  = etag_q + 1'b1;
      err_d   = 1'b1;
    end
    outs_d = outs_q + OW'(accept & rd_only) - OW'(rx_hit | tmo);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      alive_q <= 1'b0;
      flit_q  <= '0;
      itag_q  <= '0;
      etag_q  <= '0;
      outs_q  <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      flit_q  <= flit_d;
      itag_q  <= itag_d;
      etag_q  <= etag_d;
      outs_q  <= outs_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
      err_q   <= err_d;
    end
  end

  assign avmm_slave_waitrequest   = wait_c;
  assign avmm_slave_readdata      = rdata_q;
  assign avmm_slave_readdatavalid = rdv_q;
  assign noc_tx_data              = flit_q;
  assign noc_tx_valid             = (state_q == SEND);
  assign noc_rx_ready             = alive_q;
  assign err_sticky               = err_q;

endmodule

// File: tb/tb_sector_avmm_noc_bridge.sv
// tb_sector_avmm_noc_bridge: randomized self-checking bench for sector_avmm_noc_bridge.
// Expected flits and read beats come from a queue-based model of the bridge rules.
module tb_sector_avmm_noc_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] avmm_slave_address = '0;
  logic [31:0] avmm_slave_writedata = '0;
  logic        avmm_slave_write = 1'b0;
  logic        avmm_slave_read = 1'b0;
  logic        avmm_slave_waitrequest;
  logic [31:0] avmm_slave_readdata;
  logic        avmm_slave_readdatavalid;
  logic [63:0] noc_tx_data;
  logic        noc_tx_valid;
  logic        noc_tx_ready = 1'b1;
  logic [63:0] noc_rx_data = '0;
  logic        noc_rx_valid = 1'b0;
  logic        noc_rx_ready;
  logic        err_sticky;

  sector_avmm_noc_bridge dut (
    .clk                      (clk),
    .rst                      (rst),
    .avmm_slave_address       (avmm_slave_address),
    .avmm_slave_writedata     (avmm_slave_writedata),
    .avmm_slave_write         (avmm_slave_write),
    .avmm_slave_read          (avmm_slave_read),
    .avmm_slave_waitrequest   (avmm_slave_waitrequest),
    .avmm_slave_readdata      (avmm_slave_readdata),
    .avmm_slave_readdatavalid (avmm_slave_readdatavalid),
    .noc_tx_data              (noc_tx_data),
    .noc_tx_valid             (noc_tx_valid),
    .noc_tx_ready             (noc_tx_ready),
    .noc_rx_data              (noc_rx_data),
    .noc_rx_valid             (noc_rx_valid),
    .noc_rx_ready             (noc_rx_ready),
    .err_sticky               (err_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [63:0] exp_tx[$];
  logic [63:0] got_tx[$];
  logic [31:0] exp_rd[$];
  logic [31:0] got_rd[$];
  int          outq[$];
  int          issue_tag = 0;

  bit tx_rand = 1'b0;
  bit tx_fix = 1'b1;

  always @(posedge clk) begin
    #1;
    noc_tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : tx_fix;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (noc_tx_valid && noc_tx_ready) got_tx.push_back(noc_tx_data);
      if (avmm_slave_readdatavalid) got_rd.push_back(avmm_slave_readdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mk(input logic [1:0] t, input int tag,
                                     input logic [19:0] a, input logic [31:0] d);
    return {t, 4'd6, 6'(tag), a, d};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic req(input bit w, input bit r, input logic [19:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    avmm_slave_write = w;
    avmm_slave_read = r;
    avmm_slave_address = a;
    avmm_slave_writedata = d;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!avmm_slave_waitrequest) begin
        ok = 1'b1;
        @(posedge clk);
        #2;
        break;
      end
      @(posedge clk);
      #2;
    end
    avmm_slave_write = 1'b0;
    avmm_slave_read = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL req_timeout got=waitrequest_stuck exp=accept");
    end
  endtask

  task automatic do_write(input logic [19:0] a, input logic [31:0] d);
    req(1'b1, 1'b0, a, d);
    exp_tx.push_back(mk(2'b01, 0, a, d));
  endtask

  task automatic do_read(input logic [19:0] a);
    req(1'b0, 1'b1, a, 32'd0);
    exp_tx.push_back(mk(2'b10, issue_tag, a, 32'd0));
    outq.push_back(issue_tag);
    issue_tag = (issue_tag + 1) % 16;
  endtask

  task automatic drive_rsp(input logic [63:0] f);
    noc_rx_valid = 1'b1;
    noc_rx_data = f;
    @(posedge clk);
    #2;
    noc_rx_valid = 1'b0;
  endtask

  task automatic good_rsp(input logic [31:0] d);
    int t;
    t = outq.pop_front();
    exp_rd.push_back(d);
    drive_rsp(mk(2'b11, t, 20'($urandom), d));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total++;
    if (avmm_slave_waitrequest !== 1'b1 || avmm_slave_readdatavalid !== 1'b0 ||
        avmm_slave_readdata !== 32'd0 || noc_tx_valid !== 1'b0 ||
        noc_tx_data !== 64'd0 || noc_rx_ready !== 1'b0 || err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals got=wr%b rdv%b rd%h txv%b tx%h rxr%b err%b exp=1,0,0,0,0,0,0",
               avmm_slave_waitrequest, avmm_slave_readdatavalid, avmm_slave_readdata,
               noc_tx_valid, noc_tx_data, noc_rx_ready, err_sticky);
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (avmm_slave_waitrequest !== 1'b1 || noc_rx_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_early got=wr%b rxr%b exp=wr1 rxr0",
               avmm_slave_waitrequest, noc_rx_ready);
    end
    @(posedge clk);
    #2;
    total++;
    if (avmm_slave_waitrequest !== 1'b0 || noc_rx_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_edge got=wr%b rxr%b exp=wr0 rxr1",
               avmm_slave_waitrequest, noc_rx_ready);
    end
  endtask

  task automatic test_write();
    do_write(20'h00123, 32'hCAFE0001);
    total++;
    if (noc_tx_valid !== 1'b1 || noc_tx_data !== 64'h5800_0123_CAFE_0001 ||
        avmm_slave_waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL wr_send got=txv%b tx%h wr%b exp=txv1 tx5800_0123_cafe_0001 wr1",
               noc_tx_valid, noc_tx_data, avmm_slave_waitrequest);
    end
    step(1);
    total++;
    if (avmm_slave_waitrequest !== 1'b0 || noc_tx_valid !== 1'b0) begin
      bad++;
      $display("FAIL wr_done got=wr%b txv%b exp=wr0 txv0",
               avmm_slave_waitrequest, noc_tx_valid);
    end
    step(2);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL wr_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL wr_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic test_limit();
    for (int i = 0; i < 4; i++) do_read(20'($urandom));
    step(1);
    avmm_slave_read = 1'b1;
    avmm_slave_address = 20'h0BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (avmm_slave_waitrequest !== 1'b1) begin
        bad++;
        $display("FAIL lim_block%0d got=%b exp=1", i, avmm_slave_waitrequest);
      end
      step(1);
    end
    avmm_slave_read = 1'b0;
    avmm_slave_write = 1'b1;
    #1;
    total++;
    if (avmm_slave_waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL lim_write_open got=%b exp=0", avmm_slave_waitrequest);
    end
    do_write(20'h00777, 32'h1234_5678);
    step(3);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL lim_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL lim_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic test_responses();
    for (int i = 0; i < 4; i++) begin
      good_rsp(32'hA0 + 32'(i));
      step($urandom_range(0, 2));
    end
    step(3);
    total++;
    if (got_rd.size() != exp_rd.size()) begin
      bad++;
      $display("FAIL rsp_count got=%0d exp=%0d", got_rd.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      total++;
      if (got_rd[i] !== exp_rd[i]) begin
        bad++;
        $display("FAIL rsp_data%0d got=%h exp=%h", i, got_rd[i], exp_rd[i]);
      end
    end
    got_rd.delete();
    exp_rd.delete();
  endtask

  task automatic test_tx_stall();
    logic [63:0] f;
    tx_fix = 1'b0;
    step(1);
    do_write(20'hABCDE, 32'h5555_AAAA);
    f = mk(2'b01, 0, 20'hABCDE, 32'h5555_AAAA);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (noc_tx_valid !== 1'b1 || noc_tx_data !== f || avmm_slave_waitrequest !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold%0d got=txv%b tx%h wr%b exp=txv1 tx%h wr1",
                 i, noc_tx_valid, noc_tx_data, avmm_slave_waitrequest, f);
      end
      step(1);
    end
    tx_fix = 1'b1;
    step(1);
    total++;
    if (noc_tx_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_pre_ready got=%b exp=1", noc_tx_valid);
    end
    step(1);
    total++;
    if (noc_tx_valid !== 1'b0 || avmm_slave_waitrequest !== 1'b0) begin
      bad++;
      $display("FAIL stall_release got=txv%b wr%b exp=txv0 wr0",
               noc_tx_valid, avmm_slave_waitrequest);
    end
    step(2);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL stall_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL stall_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic test_random();
    int op;
    tx_rand = 1'b1;
    for (int n = 0; n < 90; n++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        do_write(20'($urandom), $urandom);
      end else if (op == 1 && outq.size() < 4) begin
        do_read(20'($urandom));
      end else if (op == 1) begin
        avmm_slave_read = 1'b1;
        avmm_slave_address = 20'($urandom);
        for (int i = 0; i < 2; i++) begin
          #1;
          total++;
          if (avmm_slave_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL rnd_block n=%0d got=%b exp=1", n, avmm_slave_waitrequest);
          end
          step(1);
        end
        avmm_slave_read = 1'b0;
      end else if (outq.size() > 0) begin
        good_rsp($urandom);
      end
      if ($urandom_range(0, 3) == 0) step(1);
    end
    tx_rand = 1'b0;
    tx_fix = 1'b1;
    while (outq.size() > 0) good_rsp($urandom);
    for (int i = 0; i < 50 && noc_tx_valid; i++) step(1);
    step(3);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL rnd_tx_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL rnd_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    total++;
    if (got_rd.size() != exp_rd.size()) begin
      bad++;
      $display("FAIL rnd_rd_count got=%0d exp=%0d", got_rd.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      total++;
      if (got_rd[i] !== exp_rd[i]) begin
        bad++;
        $display("FAIL rnd_rd%0d got=%h exp=%h", i, got_rd[i], exp_rd[i]);
      end
    end
    total++;
    if (err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL rnd_err got=%b exp=0", err_sticky);
    end
    got_tx.delete();
    exp_tx.delete();
    got_rd.delete();
    exp_rd.delete();
  endtask

  task automatic test_both();
    req(1'b1, 1'b1, 20'h13579, 32'h0F0F_F0F0);
    exp_tx.push_back(mk(2'b01, 0, 20'h13579, 32'h0F0F_F0F0));
    total++;
    if (err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL both_err got=%b exp=1", err_sticky);
    end
    do_read(20'h02468);
    good_rsp(32'h7777_0001);
    step(3);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL both_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL both_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    total++;
    if (got_rd.size() != 1 || got_rd[0] !== 32'h7777_0001) begin
      bad++;
      $display("FAIL both_rd got_n=%0d exp_n=1 exp=77770001", got_rd.size());
    end
    got_tx.delete();
    exp_tx.delete();
    got_rd.delete();
    exp_rd.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) do_read(20'($urandom));
    tx_fix = 1'b0;
    step(1);
    req(1'b1, 1'b0, 20'h0DEAD, 32'h1111_2222);
    step(2);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL mid_pre_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL mid_pre_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (avmm_slave_waitrequest !== 1'b1 || avmm_slave_readdatavalid !== 1'b0 ||
        avmm_slave_readdata !== 32'd0 || noc_tx_valid !== 1'b0 ||
        noc_tx_data !== 64'd0 || noc_rx_ready !== 1'b0 || err_sticky !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_vals got=wr%b rdv%b rd%h txv%b tx%h rxr%b err%b exp=1,0,0,0,0,0,0",
               avmm_slave_waitrequest, avmm_slave_readdatavalid, avmm_slave_readdata,
               noc_tx_valid, noc_tx_data, noc_rx_ready, err_sticky);
    end
    got_tx.delete();
    exp_tx.delete();
    outq.delete();
    issue_tag = 0;
    tx_fix = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    do_read(20'h00042);
    step(3);
    total++;
    if (got_tx.size() != 1 || got_tx[0] !== mk(2'b10, 0, 20'h00042, 32'd0)) begin
      bad++;
      $display("FAIL mid_post_flit got_n=%0d exp=%h", got_tx.size(),
               mk(2'b10, 0, 20'h00042, 32'd0));
    end
    got_tx.delete();
    exp_tx.delete();
  endtask

  task automatic test_bad_tag();
    drive_rsp(mk(2'b11, 2, 20'h0, 32'hBAD0_0002));
    step(2);
    total++;
    if (got_rd.size() != 0 || err_sticky !== 1'b1) begin
      bad++;
      $display("FAIL bad_tag got=rdv_n%0d err%b exp=rdv_n0 err1", got_rd.size(), err_sticky);
    end
    drive_rsp(mk(2'b10, 0, 20'h0, 32'hBAD0_0010));
    step(2);
    total++;
    if (got_rd.size() != 0) begin
      bad++;
      $display("FAIL bad_type got=%0d exp=0", got_rd.size());
    end
    good_rsp(32'h600D_0000);
    step(2);
    drive_rsp(mk(2'b11, 1, 20'h0, 32'hBAD0_0001));
    step(2);
    total++;
    if (got_rd.size() != 1) begin
      bad++;
      $display("FAIL bad_empty_count got=%0d exp=1", got_rd.size());
    end
    for (int i = 0; i < got_rd.size() && i < 1; i++) begin
      total++;
      if (got_rd[i] !== exp_rd[i]) begin
        bad++;
        $display("FAIL bad_good_rd got=%h exp=%h", got_rd[i], exp_rd[i]);
      end
    end
    got_rd.delete();
    exp_rd.delete();
  endtask

  task automatic test_simul();
    logic [19:0] a;
    logic [31:0] d;
    do_read(20'h00A01);
    do_read(20'h00A02);
    step(1);
    a = 20'h00A03;
    d = 32'h5150_0001;
    avmm_slave_read = 1'b1;
    avmm_slave_address = a;
    noc_rx_valid = 1'b1;
    noc_rx_data = mk(2'b11, outq[0], 20'h0, d);
    exp_tx.push_back(mk(2'b10, issue_tag, a, 32'd0));
    void'(outq.pop_front());
    exp_rd.push_back(d);
    outq.push_back(issue_tag);
    issue_tag = (issue_tag + 1) % 16;
    step(1);
    avmm_slave_read = 1'b0;
    noc_rx_valid = 1'b0;
    step(1);
    do_read(20'h00A04);
    do_read(20'h00A05);
    step(1);
    avmm_slave_read = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (avmm_slave_waitrequest !== 1'b1) begin
        bad++;
        $display("FAIL sim_block%0d got=%b exp=1", i, avmm_slave_waitrequest);
      end
      step(1);
    end
    avmm_slave_read = 1'b0;
    while (outq.size() > 0) good_rsp($urandom);
    step(3);
    total++;
    if (got_tx.size() != exp_tx.size()) begin
      bad++;
      $display("FAIL sim_tx_count got=%0d exp=%0d", got_tx.size(), exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
      total++;
      if (got_tx[i] !== exp_tx[i]) begin
        bad++;
        $display("FAIL sim_flit%0d got=%h exp=%h", i, got_tx[i], exp_tx[i]);
      end
    end
    total++;
    if (got_rd.size() != exp_rd.size()) begin
      bad++;
      $display("FAIL sim_rd_count got=%0d exp=%0d", got_rd.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < got_rd.size(); i++) begin
      total++;
      if (got_rd[i] !== exp_rd[i]) begin
        bad++;
        $display("FAIL sim_rd%0d got=%h exp=%h", i, got_rd[i], exp_rd[i]);
      end
    end
    got_tx.delete();
    exp_tx.delete();
    got_rd.delete();
    exp_rd.delete();
  endtask

  initial begin
    test_reset();
    test_write();
    test_limit();
    test_responses();
    test_tx_stall();
    test_random();
    test_both();
    test_reset_mid();
    test_bad_tag();
    test_simul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
